dsp_frame_sequencer: RTL and testbench
======================================

// Module: dsp_frame_sequencer
//
// PURPOSE
//   Sample-rate scheduler for DSPCore. On each audio sample strobe it latches the NUM_CH input samples
//   into the core's input bank, pulses the core's start, then waits a fixed PROG_LEN-cycle program run.
//   It then captures the core outputs into a stable output bank for the serializer.
//   Sits between the audio deserializer/serializer and DSPCore; flags frames dropped due to overrun.
//
// PARAMETERS
//   NUM_CH     8    channels per frame (size of core input/output banks)
//   SAMPLE_W   36   sample word width, matches DSPCore datapath
//   PROG_LEN   64   core cycles per frame, counted from the cycle after core_start; must be >= 1
//   OVR_W      8    width of overrun counter
//   FRAME_W    16   width of frame counter
//
// PORTS
//   clk            in   1                  system clock
//   reset          in   1                  asynchronous, active-high reset
//   enable         in   1                  1 = accept sample strobes; 0 = ignore them in IDLE
//   sample_strobe  in   1                  one-cycle pulse per audio sample, clk-synchronous
//   in_samples     in   [NUM_CH][SAMPLE_W] frame from deserializer, valid in strobe cycle
//   core_start     out  1                  to DSPCore start; one-cycle pulse per frame
//   core_inputs    out  [NUM_CH][SAMPLE_W] registered input bank to DSPCore inputs
//   core_outputs   in   [NUM_CH][SAMPLE_W] DSPCore outputs
//   out_samples    out  [NUM_CH][SAMPLE_W] captured results, held until next capture
//   out_valid      out  1                  one-cycle pulse when out_samples updated
//   busy           out  1                  1 whenever state != IDLE
//   overrun        out  1                  sticky: a strobe arrived while busy
//   overrun_cnt    out  OVR_W              dropped-strobe count, saturating
//   overrun_clr    in   1                  clears overrun and overrun_cnt
//   frame_cnt      out  FRAME_W            completed frames, wraps modulo 2^FRAME_W
//
// BEHAVIOUR
//   Reset (async, any state): state=IDLE, all outputs 0 (core_inputs, out_samples, counters, flags).
//   FSM: IDLE -> START -> RUN -> CAPTURE -> IDLE.
//   IDLE: strobe & enable at cycle T -> core_inputs <= in_samples, state <= START. Else hold.
//   START (cycle T+1): core_start=1 (registered, high exactly this cycle); run counter <= 0.
//   RUN (cycles T+2 .. T+1+PROG_LEN): counter increments; leave when counter == PROG_LEN-1.
//   CAPTURE (cycle T+2+PROG_LEN): out_samples <= core_outputs at end of this cycle.
//     out_valid=1 in cycle T+3+PROG_LEN with new out_samples; frame_cnt increments at that edge.
//     State back to IDLE in cycle T+3+PROG_LEN; strobe accepted in that same cycle.
//   Min strobe spacing without overrun: PROG_LEN+3 cycles.
//   core_inputs constant from T+1 until next accepted strobe; never changes during RUN.
//   busy = (state != IDLE), combinational from state register.
//   Overrun: sample_strobe while busy -> strobe dropped, frame in flight unaffected,
//     overrun <= 1, overrun_cnt += 1 saturating at 2^OVR_W-1.
//   overrun_clr: overrun <= 0, overrun_cnt <= 0. Same cycle as new overrun event: event wins,
//     overrun=1, overrun_cnt=1.
//   enable=0 in IDLE: strobes ignored, not counted as overrun. enable dropped mid-frame:
//     frame completes normally. Strobes while busy count as overrun regardless of enable.
//   frame_cnt wraps 2^FRAME_W-1 -> 0 silently.
//   Reset mid-frame: no out_valid, no core_start; next frame starts cleanly from IDLE.
//
// TESTING (bench with PROG_LEN=10, stub core: core_outputs = core_inputs + 1 per channel)
//   1 Strobe at T with in_samples[i]=i<<10 -> core_start high only at T+1; out_valid at T+13;
//     out_samples[i]=(i<<10)+1; frame_cnt=1.
//   2 Strobes spaced 13 cycles, 5 frames -> 5 out_valid pulses, overrun=0, frame_cnt=5.
//   3 Second strobe 5 cycles after first -> dropped; overrun=1, overrun_cnt=1; first frame output
//     unchanged; core_inputs unchanged during RUN.
//   4 300 strobes while busy (OVR_W=8) -> overrun_cnt saturates at 255; overrun_clr with
//     simultaneous busy strobe -> overrun_cnt=1.
//   5 enable=0, strobe in IDLE -> no core_start, busy stays 0, overrun_cnt stays 0.
//   6 Assert reset at T+6 mid-RUN -> all outputs 0 asynchronously; no out_valid; next strobe ->
//     normal frame, out_valid 13 cycles later.

Source files
------------

// File: rtl/dsp_frame_sequencer.sv
// -----------------------------------------------------------------------------
// dsp_frame_sequencer
//
// Sample-rate scheduler in front of DSPCore. An accepted sample strobe latches
// the NUM_CH-channel input frame into the core input bank. The next cycle
// carries a one-cycle core_start pulse. The sequencer then waits a fixed
// PROG_LEN-cycle program run and captures the core outputs into a stable
// output bank. Strobes that arrive while a frame is in flight are dropped
// and recorded by the sticky overrun flag and a saturating counter.
//
// Ports
//   clk_i            system clock
//   reset_i          asynchronous, active-high reset
//   enable_i         1 = accept sample strobes while idle
//   sample_strobe_i  one-cycle pulse per audio sample
//   in_samples_i     input frame, valid in the strobe cycle
//   core_start_o     one-cycle start pulse to DSPCore
//   core_inputs_o    registered input bank to DSPCore
//   core_outputs_i   DSPCore result bank
//   out_samples_o    captured results, held until the next capture
//   out_valid_o      one-cycle pulse when out_samples_o updates
//   busy_o           high whenever a frame is in flight
//   overrun_o        sticky: a strobe arrived while busy
//   overrun_cnt_o    saturating count of dropped strobes
//   overrun_clr_i    clears overrun_o and overrun_cnt_o
//   frame_cnt_o      completed frames, wraps silently
// -----------------------------------------------------------------------------
module dsp_frame_sequencer #(
    parameter int NUM_CH   = 8,
    parameter int SAMPLE_W = 36,
    parameter int PROG_LEN = 64,
    parameter int OVR_W    = 8,
    parameter int FRAME_W  = 16
) (
    input  logic                               clk_i,
    input  logic                               reset_i,
    input  logic                               enable_i,
    input  logic                               sample_strobe_i,
    input  logic [NUM_CH-1:0][SAMPLE_W-1:0]    in_samples_i,
    output logic                               core_start_o,
    output logic [NUM_CH-1:0][SAMPLE_W-1:0]    core_inputs_o,
    input  logic [NUM_CH-1:0][SAMPLE_W-1:0]    core_outputs_i,
    output logic [NUM_CH-1:0][SAMPLE_W-1:0]    out_samples_o,
    output logic                               out_valid_o,
    output logic                               busy_o,
    output logic                               overrun_o,
    output logic [OVR_W-1:0]                   overrun_cnt_o,
    input  logic                               overrun_clr_i,
    output logic [FRAME_W-1:0]                 frame_cnt_o
);

    // Run counter must be able to hold PROG_LEN-1 even when PROG_LEN == 1.
    localparam int CNT_W = (PROG_LEN > 1) ? $clog2(PROG_LEN) : 1;
    localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(PROG_LEN - 1);
    localparam logic [OVR_W-1:0] OVR_MAX  = {OVR_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        START   = 2'd1,
        RUN     = 2'd2,
        CAPTURE = 2'd3
    } state_t;

    state_t                              state_q, state_d;
    logic [CNT_W-1:0]                    run_cnt_q;
    logic                                core_start_q;
    logic [NUM_CH-1:0][SAMPLE_W-1:0]     core_inputs_q;
    logic [NUM_CH-1:0][SAMPLE_W-1:0]     out_samples_q;
    logic                                out_valid_q;
    logic                                overrun_q;
    logic [OVR_W-1:0]                    overrun_cnt_q;
    logic [FRAME_W-1:0]                  frame_cnt_q;

    logic                                busy_s;
    logic                                accept_s;
    logic                                drop_s;

    // State register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: fixed-length walk through one frame.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    state_d = START;
                end else begin
                    state_d = IDLE;
                end
            end
            START:   state_d = RUN;
            RUN: begin
                if (run_cnt_q == RUN_LAST) begin
                    state_d = CAPTURE;
                end else begin
                    state_d = RUN;
                end
            end
            CAPTURE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State-decoded controls. Strobes while busy are dropped regardless of
    // enable; enable gates only the idle accept.
    always_comb begin
        busy_s   = (state_q != IDLE);
        accept_s = (state_q == IDLE) & sample_strobe_i & enable_i;
        drop_s   = busy_s & sample_strobe_i;
    end

    // Frame datapath: input bank, start pulse, run counter, output capture.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            core_inputs_q <= '0;
            core_start_q  <= 1'b0;
            run_cnt_q     <= '0;
            out_samples_q <= '0;
            out_valid_q   <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            // Input bank changes only on accept, so it is stable through RUN.
            if (accept_s) begin
                core_inputs_q <= in_samples_i;
            end
            core_start_q <= accept_s;
            if (state_q == START) begin
                run_cnt_q <= '0;
            end else if (state_q == RUN) begin
                run_cnt_q <= run_cnt_q + CNT_W'(1);
            end
            if (state_q == CAPTURE) begin
                out_samples_q <= core_outputs_i;
                frame_cnt_q   <= frame_cnt_q + FRAME_W'(1);
            end
            out_valid_q <= (state_q == CAPTURE);
        end
    end

    // Overrun tracking: a new drop event takes priority over a clear.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            overrun_q     <= 1'b0;
            overrun_cnt_q <= '0;
        end else if (drop_s) begin
            overrun_q <= 1'b1;
            if (overrun_clr_i) begin
                overrun_cnt_q <= OVR_W'(1);
            end else if (overrun_cnt_q != OVR_MAX) begin
                overrun_cnt_q <= overrun_cnt_q + OVR_W'(1);
            end
        end else if (overrun_clr_i) begin
            overrun_q     <= 1'b0;
            overrun_cnt_q <= '0;
        end
    end

    assign core_start_o  = core_start_q;
    assign core_inputs_o = core_inputs_q;
    assign out_samples_o = out_samples_q;
    assign out_valid_o   = out_valid_q;
    assign busy_o        = busy_s;
    assign overrun_o     = overrun_q;
    assign overrun_cnt_o = overrun_cnt_q;
    assign frame_cnt_o   = frame_cnt_q;

endmodule

// File: tb/tb_dsp_frame_sequencer.sv
module tb_dsp_frame_sequencer;

    localparam int NUM_CH   = 8;
    localparam int SAMPLE_W = 36;
    localparam int PROG_LEN = 10;
    localparam int OVR_W    = 8;
    localparam int FRAME_W  = 16;
    localparam int LAT      = PROG_LEN + 3;   // strobe to out_valid

    typedef logic [NUM_CH-1:0][SAMPLE_W-1:0] bank_t;

    logic              clk = 1'b0;
    logic              reset_i;
    logic              enable_i;
    logic              sample_strobe_i;
    bank_t             in_samples_i;
    logic              core_start_o;
    bank_t             core_inputs_o;
    bank_t             core_outputs_i;
    bank_t             out_samples_o;
    logic              out_valid_o;
    logic              busy_o;
    logic              overrun_o;
    logic [OVR_W-1:0]  overrun_cnt_o;
    logic              overrun_clr_i;
    logic [FRAME_W-1:0] frame_cnt_o;

    always #5 clk = ~clk;

    dsp_frame_sequencer #(
        .NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W), .PROG_LEN(PROG_LEN),
        .OVR_W(OVR_W), .FRAME_W(FRAME_W)
    ) dut (
        .clk_i(clk), .reset_i(reset_i), .enable_i(enable_i),
        .sample_strobe_i(sample_strobe_i), .in_samples_i(in_samples_i),
        .core_start_o(core_start_o), .core_inputs_o(core_inputs_o),
        .core_outputs_i(core_outputs_i), .out_samples_o(out_samples_o),
        .out_valid_o(out_valid_o), .busy_o(busy_o), .overrun_o(overrun_o),
        .overrun_cnt_o(overrun_cnt_o), .overrun_clr_i(overrun_clr_i),
        .frame_cnt_o(frame_cnt_o)
    );

    // Stub core: every channel plus one.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) core_outputs_i[i] = core_inputs_o[i] + 36'd1;
    end

    int errors = 0;
    int checks = 0;

    // Reference model: timeline of the frame in flight, in absolute cycles.
    int                cyc;
    int                t_acc;
    bit                have;
    bank_t             cin_m;
    bank_t             out_m;
    logic [FRAME_W-1:0] frame_m;
    bit                ovr_m;
    int                ovr_cnt_m;

    function automatic bit busy_m();
        return have && (cyc >= t_acc + 1) && (cyc <= t_acc + LAT - 1);
    endfunction

    function automatic bank_t rnd_bank();
        bank_t b;
        for (int i = 0; i < NUM_CH; i++) b[i] = {$urandom_range(15, 0), $urandom()};
        return b;
    endfunction

    function automatic bank_t ramp_bank();
        bank_t b;
        for (int i = 0; i < NUM_CH; i++) b[i] = SAMPLE_W'(i) << 10;
        return b;
    endfunction

    task automatic chk(input string tag, input logic [NUM_CH*SAMPLE_W-1:0] obs,
                       input logic [NUM_CH*SAMPLE_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("core_start", core_start_o, have && (cyc == t_acc + 1));
        chk("out_valid",  out_valid_o,  have && (cyc == t_acc + LAT));
        chk("busy",       busy_o,       busy_m());
        chk("overrun",    overrun_o,    ovr_m);
        chk("overrun_cnt", overrun_cnt_o, ovr_cnt_m);
        chk("frame_cnt",  frame_cnt_o,  frame_m);
        chk("core_inputs", core_inputs_o, cin_m);
        chk("out_samples", out_samples_o, out_m);
    endtask

    task automatic model_clear();
        have = 1'b0; t_acc = -100; cin_m = '0; out_m = '0;
        frame_m = '0; ovr_m = 1'b0; ovr_cnt_m = 0;
    endtask

    // One clock cycle with the given inputs, then model update and checks.
    task automatic step(input bit s, input bit en, input bit clr, input bank_t samp);
        bit b, acc, ov;
        sample_strobe_i = s; enable_i = en; overrun_clr_i = clr; in_samples_i = samp;
        b   = busy_m();
        acc = s && en && !b;
        ov  = s && b;
        @(posedge clk); #1;
        if (have && (cyc + 1 == t_acc + LAT)) begin
            for (int i = 0; i < NUM_CH; i++) out_m[i] = cin_m[i] + 36'd1;
            frame_m = frame_m + 16'd1;
        end
        if (acc) begin
            have = 1'b1; t_acc = cyc; cin_m = samp;
        end
        if (ov) begin
            ovr_m = 1'b1;
            ovr_cnt_m = clr ? 1 : ((ovr_cnt_m < 255) ? ovr_cnt_m + 1 : 255);
        end else if (clr) begin
            ovr_m = 1'b0; ovr_cnt_m = 0;
        end
        cyc++;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b1, 1'b0, rnd_bank());
    endtask

    // Asynchronous reset pulse between clock edges.
    task automatic do_reset();
        sample_strobe_i = 1'b0; overrun_clr_i = 1'b0;
        #2 reset_i = 1'b1;
        #1 model_clear();
        check_all();
        @(negedge clk) reset_i = 1'b0;
        @(posedge clk); #1;
        cyc++;
        check_all();
    endtask

    initial begin
        reset_i = 1'b1; enable_i = 1'b0; sample_strobe_i = 1'b0;
        overrun_clr_i = 1'b0; in_samples_i = '0;
        cyc = 0;
        model_clear();
        repeat (2) @(posedge clk);
        #1 check_all();
        @(negedge clk) reset_i = 1'b0;
        @(posedge clk); #1;
        check_all();

        // 1: single frame with ramp data.
        step(1'b1, 1'b1, 1'b0, ramp_bank());
        idle(LAT);
        chk("t1_frame_cnt", frame_cnt_o, 16'd1);
        chk("t1_out_ch3", out_samples_o[3], 36'd3073);

        // 2: five back-to-back frames at minimum spacing.
        for (int f = 0; f < 5; f++) begin
            step(1'b1, 1'b1, 1'b0, rnd_bank());
            idle(LAT - 1);
        end
        idle(1);
        chk("t2_frame_cnt", frame_cnt_o, 16'd6);
        chk("t2_overrun", overrun_o, 1'b0);

        // 3: second strobe 5 cycles after the first is dropped.
        step(1'b1, 1'b1, 1'b0, rnd_bank());
        idle(4);
        step(1'b1, 1'b1, 1'b0, rnd_bank());
        idle(LAT);
        chk("t3_overrun_cnt", overrun_cnt_o, 8'd1);

        // 4: saturate the overrun counter, then clear with a simultaneous drop.
        for (int k = 0; k < 330; k++) step(1'b1, 1'b1, 1'b0, rnd_bank());
        chk("t4_saturated", overrun_cnt_o, 8'd255);
        for (int k = 0; k < 20 && !busy_m(); k++) step(1'b1, 1'b1, 1'b0, rnd_bank());
        step(1'b1, 1'b1, 1'b1, rnd_bank());
        chk("t4_clr_vs_event", overrun_cnt_o, 8'd1);
        idle(LAT);
        step(1'b0, 1'b1, 1'b1, rnd_bank());

        // 5: disabled strobe in idle is ignored.
        step(1'b1, 1'b0, 1'b0, rnd_bank());
        chk("t5_busy", busy_o, 1'b0);
        idle(3);

        // 6: reset mid-run, then a clean frame.
        step(1'b1, 1'b1, 1'b0, rnd_bank());
        idle(5);
        do_reset();
        idle(LAT);
        step(1'b1, 1'b1, 1'b0, ramp_bank());
        idle(LAT);

        // Random phase: strobes, enable and clears at random.
        for (int k = 0; k < 600; k++) begin
            step($urandom_range(5, 0) == 0, $urandom_range(7, 0) != 0,
                 $urandom_range(39, 0) == 0, rnd_bank());
        end
        idle(LAT);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
